// File: rtl/seq_detect_datapath_pkg.sv
// Shared constants for the sequence-detect datapath and its controller.
package seq_detect_datapath_pkg;

  localparam int                PAT_W    = 4;
  localparam logic [PAT_W-1:0]  PATTERN  = 4'b1101;
  localparam int                DATA_W   = 8;
  localparam int                CNT_W    = 3;
  localparam logic [CNT_W-1:0]  CNT_LAST = 3'd7;

endpackage

// File: rtl/seq_detect_datapath_if.sv
// Control/status bundle between the sequencing controller and the datapath.
interface seq_detect_datapath_if #(
  parameter int DATA_W = seq_detect_datapath_pkg::DATA_W
);

  logic              ser_in;
  logic              en_det;
  logic              set_8;
  logic              en_cnt_8;
  logic              ld_down;
  logic              en_downcnt;
  logic              out_det;
  logic              out_cnt_8;
  logic              out_downcnt;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] down_val;

  // Controller side: drives the serial stream and enables, observes status.
  modport master (
    output ser_in, en_det, set_8, en_cnt_8, ld_down, en_downcnt,
    input  out_det, out_cnt_8, out_downcnt, data_out, down_val
  );

  // Datapath side.
  modport slave (
    input  ser_in, en_det, set_8, en_cnt_8, ld_down, en_downcnt,
    output out_det, out_cnt_8, out_downcnt, data_out, down_val
  );

endinterface

// File: rtl/seq_detect_datapath_down_counter.sv
// Loadable down counter: load beats decrement, and it parks at zero.
module down_counter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] cnt,
  output logic              zero
);

  // Load takes priority; decrement only while nonzero so there is no wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= din;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - DATA_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_detect_datapath.sv
// Datapath for the sequence-detect / up-count / down-count controller:
// pattern shifter, 8-bit serial capture, and a loadable down counter.
module seq_detect_datapath #(
  parameter int               PAT_W   = seq_detect_datapath_pkg::PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = seq_detect_datapath_pkg::PATTERN,
  parameter int               DATA_W  = seq_detect_datapath_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_detect_datapath_if.slave  bus
);

  import seq_detect_datapath_pkg::*;

  // fill counts valid bits in the shifter so stale zeros never look like a match.
  localparam logic [2:0] FILL_FULL = 3'(PAT_W);

  logic [PAT_W-1:0]  pat_sr;
  logic [2:0]        fill;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] down_cnt;
  logic              down_zero;

  // Pattern shifter; matches may overlap, so a hit never clears it.
  always_ff @(posedge clk) begin
    if (rst || bus.set_8) begin
      pat_sr <= '0;
      fill   <= '0;
    end else if (bus.en_det) begin
      pat_sr <= {pat_sr[PAT_W-2:0], bus.ser_in};
      if (fill != FILL_FULL) begin
        fill <= fill + 3'd1;
      end
    end
  end

  // MSB-first byte capture with a wrapping bit counter.
  always_ff @(posedge clk) begin
    if (rst || bus.set_8) begin
      data_sr <= '0;
      cnt     <= '0;
    end else if (bus.en_cnt_8) begin
      data_sr <= {data_sr[DATA_W-2:0], bus.ser_in};
      cnt     <= cnt + CNT_W'(1);
    end
  end

  down_counter #(
    .DATA_W (DATA_W)
  ) u_down_counter (
    .clk  (clk),
    .rst  (rst),
    .ld   (bus.ld_down),
    .en   (bus.en_downcnt),
    .din  (data_sr),
    .cnt  (down_cnt),
    .zero (down_zero)
  );

  assign bus.out_det     = (fill == FILL_FULL) && (pat_sr == PATTERN);
  assign bus.out_cnt_8   = (cnt == CNT_LAST);
  assign bus.out_downcnt = down_zero;
  assign bus.data_out    = data_sr;
  assign bus.down_val    = down_cnt;

endmodule

// File: tb/tb_seq_detect_datapath.sv
// Directed bench for seq_detect_datapath.
module tb_seq_detect_datapath;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  seq_detect_datapath_if #(.DATA_W(8)) bus ();

  seq_detect_datapath dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.ser_in     = 1'b0;
    bus.en_det     = 1'b0;
    bus.set_8      = 1'b0;
    bus.en_cnt_8   = 1'b0;
    bus.ld_down    = 1'b0;
    bus.en_downcnt = 1'b0;
  endtask

  task automatic clear8();
    idle();
    bus.set_8 = 1'b1;
    tick();
    bus.set_8 = 1'b0;
  endtask

  task automatic capture(input logic [7:0] b, input string tag);
    idle();
    bus.en_cnt_8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.ser_in = b[7-i];
      chk1({tag, "_cnt8"}, bus.out_cnt_8, (i == 7));
      tick();
    end
    idle();
  endtask

  initial begin
    logic [3:0] pat;
    logic [6:0] ovl;
    logic [6:0] hist;

    vectors     = 0;
    miscompares = 0;
    idle();

    // 1. reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk1("rst_det", bus.out_det, 1'b0);
    chk1("rst_cnt8", bus.out_cnt_8, 1'b0);
    chk1("rst_dz", bus.out_downcnt, 1'b1);
    chk8("rst_data", bus.data_out, 8'h00);
    chk8("rst_down", bus.down_val, 8'h00);

    // 2. single detection, then all-zero stream
    clear8();
    pat = 4'b1101;
    bus.en_det = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ser_in = pat[3-i];
      chk1("det_early", bus.out_det, 1'b0);
      tick();
    end
    chk1("det_hit", bus.out_det, 1'b1);
    clear8();
    chk1("det_clr", bus.out_det, 1'b0);
    bus.en_det = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ser_in = 1'b0;
      tick();
      chk1("det_zero", bus.out_det, 1'b0);
    end

    // 3. overlapping matches, 3 cycles apart
    clear8();
    ovl  = 7'b1101101;
    hist = '0;
    bus.en_det = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.ser_in = ovl[6-i];
      tick();
      hist[i] = bus.out_det;
    end
    chk8("det_overlap", {1'b0, hist}, 8'h48);

    // 4. byte capture
    clear8();
    capture(8'hA6, "cap_a6");
    chk8("cap_data", bus.data_out, 8'hA6);
    chk8("cap_cntz", {5'd0, dut.cnt}, 8'h00);
    chk1("cap_cnt8_off", bus.out_cnt_8, 1'b0);

    // 5. down counter
    clear8();
    capture(8'h03, "cap_03");
    chk8("ld_data", bus.data_out, 8'h03);
    bus.ld_down    = 1'b1;
    bus.en_downcnt = 1'b1;
    tick();
    bus.ld_down = 1'b0;
    chk8("ld_val", bus.down_val, 8'h03);
    chk1("ld_dz", bus.out_downcnt, 1'b0);
    tick();
    chk8("dn_2", bus.down_val, 8'h02);
    tick();
    chk8("dn_1", bus.down_val, 8'h01);
    chk1("dn_1_dz", bus.out_downcnt, 1'b0);
    tick();
    chk8("dn_0", bus.down_val, 8'h00);
    chk1("dn_0_dz", bus.out_downcnt, 1'b1);
    tick();
    chk8("dn_hold", bus.down_val, 8'h00);
    chk1("dn_hold_dz", bus.out_downcnt, 1'b1);
    idle();
    bus.ld_down = 1'b1;
    tick();
    idle();
    chk8("reld_val", bus.down_val, 8'h03);
    clear8();
    chk8("set8_data", bus.data_out, 8'h00);
    chk8("set8_down", bus.down_val, 8'h03);
    bus.ld_down = 1'b1;
    tick();
    idle();
    chk8("ld0_val", bus.down_val, 8'h00);
    chk1("ld0_dz", bus.out_downcnt, 1'b1);

    // 6. mid-operation reset, then a full sequence
    clear8();
    bus.en_det   = 1'b1;
    bus.en_cnt_8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.ser_in = 1'b1;
      tick();
    end
    idle();
    bus.ld_down = 1'b1;
    tick();
    idle();
    chk8("pre_rst_down", bus.down_val, 8'h1F);
    chk8("pre_rst_data", bus.data_out, 8'h1F);
    rst            = 1'b1;
    bus.ser_in     = 1'b1;
    bus.en_det     = 1'b1;
    bus.en_cnt_8   = 1'b1;
    bus.en_downcnt = 1'b1;
    bus.ld_down    = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk8("mrst_data", bus.data_out, 8'h00);
    chk8("mrst_down", bus.down_val, 8'h00);
    chk1("mrst_dz", bus.out_downcnt, 1'b1);
    chk1("mrst_det", bus.out_det, 1'b0);
    chk1("mrst_cnt8", bus.out_cnt_8, 1'b0);
    chk8("mrst_cnt", {5'd0, dut.cnt}, 8'h00);
    chk8("mrst_pat", {4'd0, dut.pat_sr}, 8'h00);
    chk8("mrst_fill", {5'd0, dut.fill}, 8'h00);

    bus.en_det = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ser_in = pat[3-i];
      tick();
    end
    chk1("full_det", bus.out_det, 1'b1);
    capture(8'h5C, "full");
    chk8("full_data", bus.data_out, 8'h5C);
    bus.ld_down = 1'b1;
    tick();
    idle();
    chk8("full_down", bus.down_val, 8'h5C);
    chk1("full_dz", bus.out_downcnt, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
